// File: rtl/tbl_access_arb.sv
// Arbitrates a shared dual-port table RAM between one config writer and two
// lookup requesters. Writes go straight to RAM port A; lookups are granted
// round-robin onto port B. Each requester may have one lookup in flight.
module tbl_access_arb #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 625
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_wr_valid,
    input  logic [ADDR_BITS-1:0] cfg_wr_addr,
    input  logic [DATA_BITS-1:0] cfg_wr_data,
    output logic                 cfg_wr_ready,
    input  logic                 lk0_req_valid,
    input  logic [ADDR_BITS-1:0] lk0_req_addr,
    output logic                 lk0_req_ready,
    input  logic                 lk1_req_valid,
    input  logic [ADDR_BITS-1:0] lk1_req_addr,
    output logic                 lk1_req_ready,
    output logic                 lk0_rsp_valid,
    output logic [DATA_BITS-1:0] lk0_rsp_data,
    input  logic                 lk0_rsp_ready,
    output logic                 lk1_rsp_valid,
    output logic [DATA_BITS-1:0] lk1_rsp_data,
    input  logic                 lk1_rsp_ready,
    output logic [ADDR_BITS-1:0] ram_addra,
    output logic [DATA_BITS-1:0] ram_dina,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic [ADDR_BITS-1:0] ram_addrb,
    output logic                 ram_enb,
    input  logic [DATA_BITS-1:0] ram_doutb
);

    logic [1:0]           busy_q, busy_d;
    logic                 last_grant_q, last_grant_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_tag_q, s1_tag_d;
    logic [1:0]           rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_BITS-1:0] rsp1_data_q, rsp1_data_d;

    logic [1:0]           elig;
    logic [1:0]           gnt;
    logic [1:0]           rsp_hs;
    logic                 wr_fire;

    // Write port passes straight through; everything is forced low in reset.
    always_comb begin
        wr_fire      = cfg_wr_valid & ~rst;
        cfg_wr_ready = ~rst;
        ram_ena      = wr_fire;
        ram_wea      = wr_fire;
        ram_addra    = rst ? '0 : cfg_wr_addr;
        ram_dina     = rst ? '0 : cfg_wr_data;
    end

    // Eligibility with same-address write stall, then round-robin pick.
    always_comb begin
        elig[0] = lk0_req_valid & ~busy_q[0] & ~rst &
                  ~(cfg_wr_valid && (lk0_req_addr == cfg_wr_addr));
        elig[1] = lk1_req_valid & ~busy_q[1] & ~rst &
                  ~(cfg_wr_valid && (lk1_req_addr == cfg_wr_addr));
        if (elig == 2'b11) begin
            gnt = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            gnt = elig;
        end
        lk0_req_ready = gnt[0];
        lk1_req_ready = gnt[1];
        ram_enb       = |gnt;
        if (gnt[1]) begin
            ram_addrb = lk1_req_addr;
        end else if (gnt[0]) begin
            ram_addrb = lk0_req_addr;
        end else begin
            ram_addrb = '0;
        end
    end

    // Response outputs come from flops, masked to zero while reset is held.
    always_comb begin
        rsp_hs[0]     = rsp_valid_q[0] & lk0_rsp_ready;
        rsp_hs[1]     = rsp_valid_q[1] & lk1_rsp_ready;
        lk0_rsp_valid = rsp_valid_q[0] & ~rst;
        lk1_rsp_valid = rsp_valid_q[1] & ~rst;
        lk0_rsp_data  = rst ? '0 : rsp0_data_q;
        lk1_rsp_data  = rst ? '0 : rsp1_data_q;
    end

    // Next state: busy tracking, grant pointer and the two-stage read return.
    always_comb begin
        busy_d       = (busy_q | gnt) & ~rsp_hs;
        last_grant_d = (|gnt) ? gnt[1] : last_grant_q;
        s1_valid_d   = |gnt;
        s1_tag_d     = gnt[1];
        rsp_valid_d  = rsp_valid_q & ~rsp_hs;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        if (s1_valid_q) begin
            if (s1_tag_q) begin
                rsp_valid_d[1] = 1'b1;
                rsp1_data_d    = ram_doutb;
            end else begin
                rsp_valid_d[0] = 1'b1;
                rsp0_data_d    = ram_doutb;
            end
        end
    end

    // State registers; reset drops any in-flight or unconsumed lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            last_grant_q <= 1'b1;
            s1_valid_q   <= 1'b0;
            s1_tag_q     <= 1'b0;
            rsp_valid_q  <= '0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_tag_q     <= s1_tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

endmodule

// File: tb/tb_tbl_access_arb.sv
// Scoreboard bench for tbl_access_arb: a reference model predicts grants and
// pushes expected responses; a separate monitor pops them on DUT responses.
module tb_tbl_access_arb;
    localparam int AW = 4;
    localparam int DW = 625;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wv;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wready;
    logic [1:0]    req_valid;
    logic [AW-1:0] req_addr [2];
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_data0, rsp_data1;
    logic [1:0]    rsp_ready;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dina, ram_doutb;
    logic          ram_ena, ram_wea, ram_enb;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t          exp_q [2][$];
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] shadow [16];
    logic          fair_win = 1'b0;
    logic          bp_win = 1'b0;
    int            fair_g0 = 0, fair_g1 = 0, bp_g1 = 0;

    tbl_access_arb #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr_valid(wv), .cfg_wr_addr(waddr), .cfg_wr_data(wdata), .cfg_wr_ready(wready),
        .lk0_req_valid(req_valid[0]), .lk0_req_addr(req_addr[0]), .lk0_req_ready(req_ready[0]),
        .lk1_req_valid(req_valid[1]), .lk1_req_addr(req_addr[1]), .lk1_req_ready(req_ready[1]),
        .lk0_rsp_valid(rsp_valid[0]), .lk0_rsp_data(rsp_data0), .lk0_rsp_ready(rsp_ready[0]),
        .lk1_rsp_valid(rsp_valid[1]), .lk1_rsp_data(rsp_data1), .lk1_rsp_ready(rsp_ready[1]),
        .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_ena(ram_ena), .ram_wea(ram_wea),
        .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_doutb(ram_doutb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Simple-dual-port RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dina;
        if (ram_enb) ram_doutb <= ram_mem[ram_addrb];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d = '0;
        for (int i = 0; i < DW; i += 32) d = {d[DW-33:0], $urandom()};
        return d;
    endfunction

    // Reference model: per-cycle grant prediction and expected response timing.
    initial begin : model
        logic [1:0] m_busy;
        int         m_due [2];
        int         m_last;
        logic [1:0] el, ev;
        logic [1:0] exp_rdy;
        int         g;
        exp_t       e;
        m_busy = '0;
        m_last = 1;
        m_due[0] = 0;
        m_due[1] = 0;
        for (int a = 0; a < 16; a++) shadow[a] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_outputs_zero",
                    DW'(|{wready, req_ready, rsp_valid, rsp_data0, rsp_data1,
                          ram_addra, ram_dina, ram_ena, ram_wea, ram_addrb, ram_enb}), '0);
                m_busy = '0;
                m_last = 1;
                exp_q[0].delete();
                exp_q[1].delete();
                continue;
            end
            for (int n = 0; n < 2; n++) begin
                ev[n] = m_busy[n] && (cyc >= m_due[n]);
                el[n] = req_valid[n] && !m_busy[n] && !(wv && req_addr[n] == waddr);
            end
            chk("rsp_valid", DW'(rsp_valid), DW'(ev));
            if (el[0] && el[1]) g = 1 - m_last;
            else if (el[0]) g = 0;
            else if (el[1]) g = 1;
            else g = -1;
            exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
            chk("req_ready", DW'(req_ready), DW'(exp_rdy));
            chk("ram_enb", DW'(ram_enb), DW'(g >= 0));
            chk("ram_addrb", DW'(ram_addrb), (g < 0) ? '0 : DW'(req_addr[g]));
            chk("cfg_wr_ready", DW'(wready), DW'(1));
            chk("ram_ena_wea", DW'({ram_ena, ram_wea}), DW'({wv, wv}));
            if (wv) begin
                chk("ram_addra", DW'(ram_addra), DW'(waddr));
                chk("ram_dina", ram_dina, wdata);
            end
            if (fair_win) begin
                fair_g0 += int'(req_ready[0]);
                fair_g1 += int'(req_ready[1]);
            end
            if (bp_win) bp_g1 += int'(req_ready[1]);
            for (int n = 0; n < 2; n++) if (ev[n] && rsp_ready[n]) m_busy[n] = 1'b0;
            if (g >= 0) begin
                m_busy[g] = 1'b1;
                m_due[g]  = cyc + 2;
                m_last    = g;
                e.data    = shadow[req_addr[g]];
                e.due     = cyc + 2;
                exp_q[g].push_back(e);
            end
            if (wv) shadow[waddr] = wdata;
        end
    end

    // Monitor: pops expected responses when the DUT presents them.
    initial begin : monitor
        logic [1:0]    pend;
        logic [DW-1:0] d;
        pend = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = '0;
                continue;
            end
            for (int n = 0; n < 2; n++) begin
                d = (n == 0) ? rsp_data0 : rsp_data1;
                if (!rsp_valid[n]) begin
                    pend[n] = 1'b0;
                end else if (exp_q[n].size() == 0) begin
                    chk(n == 0 ? "rsp0_unexpected" : "rsp1_unexpected", DW'(1), DW'(0));
                end else begin
                    chk(n == 0 ? "rsp0_data" : "rsp1_data", d, exp_q[n][0].data);
                    if (!pend[n])
                        chk(n == 0 ? "rsp0_latency" : "rsp1_latency", DW'(cyc), DW'(exp_q[n][0].due));
                    if (rsp_ready[n]) begin
                        void'(exp_q[n].pop_front());
                        pend[n] = 1'b0;
                    end else begin
                        pend[n] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        wv = 1'b0;
        req_valid = '0;
        rsp_ready = 2'b11;
    endtask

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin : driver
        rst = 1'b1;
        wv = 1'b0;
        waddr = '0;
        wdata = '0;
        req_valid = '0;
        req_addr[0] = '0;
        req_addr[1] = '0;
        rsp_ready = 2'b11;
        step(3);
        rst = 1'b0;

        for (int a = 0; a < 16; a++) begin
            wv = 1'b1; waddr = AW'(a); wdata = rand_data();
            step();
        end
        idle_inputs();
        step();

        // basic write then read
        wv = 1'b1; waddr = 4'd3; wdata = DW'(8'hA5);
        step();
        wv = 1'b0; req_valid[0] = 1'b1; req_addr[0] = 4'd3;
        step();
        idle_inputs();
        step(4);

        // same-address hazard
        wv = 1'b1; waddr = 4'd5; wdata = DW'(8'h11);
        req_valid[1] = 1'b1; req_addr[1] = 4'd5;
        step();
        wv = 1'b0;
        step();
        idle_inputs();
        step(4);

        // fairness under continuous demand
        fair_win = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 100; i++) begin
            req_addr[0] = AW'($urandom_range(0, 15));
            req_addr[1] = AW'($urandom_range(0, 15));
            step();
        end
        fair_win = 1'b0;
        idle_inputs();
        step(4);
        chk("fair_lk0_grants_ge30", DW'(fair_g0 >= 30), DW'(1));
        chk("fair_lk1_grants_ge30", DW'(fair_g1 >= 30), DW'(1));

        // backpressure on lk0 while lk1 keeps going
        req_valid[0] = 1'b1; req_addr[0] = 4'd9;
        rsp_ready[0] = 1'b0;
        step();
        bp_win = 1'b1;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_addr[1] = AW'($urandom_range(0, 15));
            step();
        end
        bp_win = 1'b0;
        chk("bp_lk1_served", DW'(bp_g1 >= 3), DW'(1));
        idle_inputs();
        step(4);

        // reset pulse while a lookup is in flight, then a tie
        req_valid[0] = 1'b1; req_addr[0] = 4'd1;
        step();
        req_valid[0] = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 2'b11; req_addr[0] = 4'd4; req_addr[1] = 4'd6;
        step();
        idle_inputs();
        step(4);

        // write and read to different addresses in the same cycle
        wv = 1'b1; waddr = 4'd2; wdata = rand_data();
        req_valid[0] = 1'b1; req_addr[0] = 4'd7;
        step();
        idle_inputs();
        step(4);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            wv = ($urandom_range(0, 3) == 0);
            waddr = AW'($urandom_range(0, 15));
            wdata = rand_data();
            req_valid = 2'($urandom_range(0, 3));
            req_addr[0] = AW'($urandom_range(0, 15));
            req_addr[1] = AW'($urandom_range(0, 15));
            rsp_ready = 2'($urandom_range(0, 3));
            step();
        end

        idle_inputs();
        step(8);
        chk("drain_q0_empty", DW'(exp_q[0].size()), DW'(0));
        chk("drain_q1_empty", DW'(exp_q[1].size()), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
